frame_mixer: RTL and testbench
==============================

FRAME_MIXER -- requirements
Module: frame_mixer

Interface
REQ-001 SHALL have parameter N_LAYERS, default 4: number of sprite layers, legal range 2..8.
REQ-002 SHALL have parameter RGB_W, default 12 (`COLOR_RGB_DEPTH): pixel colour width.
REQ-003 SHALL have parameter BG_RGB, default 0: colour shown when no alpha is set.
REQ-004 SHALL have parameter INFO_RGB, default all-ones: colour of the info overlay.
REQ-005 SHALL have parameter FATAL_MASK, N_LAYERS*N_LAYERS bits, default bit 1 set: collision pairs that end the game.
REQ-006 SHALL have port clk_vga, input, 1: sole clock; one clock, all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port disp_i, input, 1: current pixel is inside the visible area.
REQ-009 SHALL have port v_sync_i, input, 1: vertical sync, active-low.
REQ-010 SHALL have port rgb_i, input, N_LAYERS*RGB_W: packed layer colours, layer k at bits [k*RGB_W +: RGB_W].
REQ-011 SHALL have port alpha_i, input, N_LAYERS: per-layer opacity of the current pixel.
REQ-012 SHALL have port info_alpha_i, input, 1: info overlay opacity.
REQ-013 SHALL have port gamestart_i, input, 1: start/restart pulse.
REQ-014 SHALL have port rgb_o, output, RGB_W: mixed pixel colour.
REQ-015 SHALL have port crash_o, output, N_LAYERS*N_LAYERS: per-frame collision matrix pulse, bit i*N_LAYERS+j.
REQ-016 SHALL have port game_status_o, output, 2 (`GAME_STATUS_BIT_LEN): IDLE=0, RUN=1, OVER=2.

Function
REQ-017 SHALL register rgb_o with 1-cycle latency from rgb_i/alpha_i/info_alpha_i/disp_i.
REQ-018 SHALL set rgb_o to 0 when disp_i=0; else INFO_RGB if info_alpha_i=1; else rgb of the lowest-index set alpha_i bit (layer 0 = highest priority); else BG_RGB.
REQ-019 SHALL detect a frame boundary as a falling edge of v_sync_i (previous sample 1, current 0) using one internal register.
REQ-020 SHALL, while status=RUN and disp_i=1, set sticky accumulator bit i*N+j for every pair i<j with alpha_i[i]&alpha_i[j]; bits with i>=j are always 0.
REQ-021 SHALL, on the cycle after a frame boundary is detected, drive crash_o with the accumulated matrix for exactly one cycle and clear the accumulator; crash_o SHALL be 0 at all other times.
REQ-022 SHALL place a hit occurring in the boundary cycle itself into the new (cleared) accumulator, never losing it.
REQ-023 SHALL implement FSM IDLE->RUN on gamestart_i; RUN->OVER when the accumulator value being emitted on crash_o, ANDed with FATAL_MASK, is non-zero; OVER->RUN on gamestart_i.
REQ-024 SHALL clear the accumulator on every transition into RUN.
REQ-025 SHALL ignore gamestart_i while in RUN.
REQ-026 SHALL keep the accumulator and crash_o at 0 in IDLE and OVER; rgb_o mixing continues in all states.
REQ-027 SHALL update game_status_o in the same cycle as the state register, with no extra latency.

Reset
REQ-028 SHALL on rst=1 set rgb_o=0, crash_o=0, game_status_o=IDLE, clear the accumulator, and set the v_sync history register to 1.
REQ-029 SHALL let rst override every other input, including mid-frame and in the same cycle as gamestart_i.

Structure
REQ-030 SHALL take status encodings, GAME_STATUS_BIT_LEN and COLOR_RGB_DEPTH from the shared define header; none are redefined locally.
REQ-031 SHALL place pair detection and the sticky accumulator in one sub-module, pair_hit_acc, parametrised by N_LAYERS.

Verification (N_LAYERS=4, RGB_W=12)
REQ-032 SHALL cover: disp_i=1, alpha_i=4'b0110, rgb layers 1/2 = 12'h0F0/12'hF00 -> rgb_o=12'h0F0 one cycle later; add info_alpha_i=1 -> rgb_o=12'hFFF.
REQ-033 SHALL cover: RUN, alpha_i=4'b1100 for 3 pixels in a frame, then v_sync_i falls -> crash_o bit 11 (2*4+3) high for exactly one cycle, then 0; status stays RUN.
REQ-034 SHALL cover: RUN, alpha_i=4'b0011 once, then frame boundary -> crash_o bit 1 pulses; next cycle game_status_o=2; a second gamestart_i pulse -> game_status_o=1 and accumulator cleared.
REQ-035 SHALL cover: IDLE, alpha_i=4'b1111 for a full frame -> crash_o stays 0 and status stays 0.
REQ-036 SHALL cover: hit 4'b0101 in the same cycle v_sync_i falls -> bit 2 absent from the current crash_o pulse and present in the next frame's pulse.
REQ-037 SHALL cover: rst asserted mid-frame with accumulator non-zero -> all outputs 0 next cycle, status IDLE, and no crash_o pulse at the following boundary.

Source files
------------

// File: rtl/frame_mixer_pkg.sv
// Shared defines and types for the frame mixer: colour depth, game status
// encodings and the collision-pair bit numbering.
`ifndef FRAME_MIXER_DEFINES_SVH
`define FRAME_MIXER_DEFINES_SVH
`define COLOR_RGB_DEPTH     12
`define GAME_STATUS_BIT_LEN 2
`define GAME_STATUS_IDLE    2'd0
`define GAME_STATUS_RUN     2'd1
`define GAME_STATUS_OVER    2'd2
`endif

package frame_mixer_pkg;

  typedef enum logic [`GAME_STATUS_BIT_LEN-1:0] {
    ST_IDLE = `GAME_STATUS_IDLE,
    ST_RUN  = `GAME_STATUS_RUN,
    ST_OVER = `GAME_STATUS_OVER
  } game_state_t;

  // Collision matrix bit for the layer pair (i, j); only i < j is ever set.
  function automatic int unsigned pair_bit(input int unsigned i,
                                           input int unsigned j,
                                           input int unsigned n);
    return i * n + j;
  endfunction

endpackage

// File: rtl/frame_mixer_pair_hit_acc.sv
// Layer-pair overlap detection with a sticky per-frame accumulator.
module pair_hit_acc
  import frame_mixer_pkg::*;
#(
  parameter int N_LAYERS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_hit_en,
  input  logic                           i_frame_restart,
  input  logic                           i_hold_clear,
  input  logic [N_LAYERS-1:0]            i_alpha,
  output logic [N_LAYERS*N_LAYERS-1:0]   o_acc
);

  localparam int NN = N_LAYERS * N_LAYERS;

  logic [NN-1:0] w_hits;
  logic [NN-1:0] r_acc;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_hits = '0;
    for (int i = 0; i < N_LAYERS; i++) begin
      for (int j = i + 1; j < N_LAYERS; j++) begin
        w_hits[pair_bit(i, j, N_LAYERS)] = i_alpha[i] & i_alpha[j];
      end
    end
  end

  // A hit in the restart cycle lands in the freshly cleared matrix.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || i_hold_clear) begin
      r_acc <= '0;
    end else begin
      r_acc <= (i_frame_restart ? '0 : r_acc) | (i_hit_en ? w_hits : '0);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/frame_mixer.sv
// Sprite layer mixer with per-frame collision reporting and a small game
// status FSM (IDLE / RUN / OVER), all on clk_vga.
module frame_mixer
  import frame_mixer_pkg::*;
#(
  parameter int                             N_LAYERS   = 4,
  parameter int                             RGB_W      = `COLOR_RGB_DEPTH,
  parameter logic [RGB_W-1:0]               BG_RGB     = '0,
  parameter logic [RGB_W-1:0]               INFO_RGB   = '1,
  parameter logic [N_LAYERS*N_LAYERS-1:0]   FATAL_MASK = (N_LAYERS*N_LAYERS)'(2)
) (
  input  logic                              clk_vga,
  input  logic                              rst,
  input  logic                              disp_i,
  input  logic                              v_sync_i,
  input  logic [N_LAYERS*RGB_W-1:0]         rgb_i,
  input  logic [N_LAYERS-1:0]               alpha_i,
  input  logic                              info_alpha_i,
  input  logic                              gamestart_i,
  output logic [RGB_W-1:0]                  rgb_o,
  output logic [N_LAYERS*N_LAYERS-1:0]      crash_o,
  output logic [`GAME_STATUS_BIT_LEN-1:0]   game_status_o
);

  localparam int NN = N_LAYERS * N_LAYERS;

  game_state_t      r_state;
  game_state_t      w_state_next;
  logic             r_vs_prev;
  logic             w_boundary;
  logic             w_run_now;
  logic             w_run_next;
  logic [RGB_W-1:0] w_mix;
  logic [RGB_W-1:0] r_rgb;
  logic [NN-1:0]    w_acc;
  logic [NN-1:0]    r_crash;

  // Scanning from the highest index down lets layer 0 win the priority.
  always_comb begin
    w_mix = BG_RGB;
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      if (alpha_i[k]) w_mix = rgb_i[k*RGB_W +: RGB_W];
    end
    if (info_alpha_i) w_mix = INFO_RGB;
    if (!disp_i)      w_mix = '0;
  end

  assign w_boundary = r_vs_prev & ~v_sync_i;
  assign w_run_now  = (r_state == ST_RUN);
  assign w_run_next = (w_state_next == ST_RUN);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (gamestart_i) w_state_next = ST_RUN;
      ST_RUN:  if (|(r_crash & FATAL_MASK)) w_state_next = ST_OVER;
      ST_OVER: if (gamestart_i) w_state_next = ST_RUN;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_vs_prev <= 1'b1;
      r_rgb     <= '0;
      r_crash   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_vs_prev <= v_sync_i;
      r_rgb     <= w_mix;
      r_crash   <= (w_run_now && w_boundary) ? w_acc : '0;
    end
  end

  // Held clear whenever the next state is not RUN, which also gives a clean
  // matrix on every entry into RUN.
  pair_hit_acc #(
    .N_LAYERS (N_LAYERS)
  ) u_pair_hit_acc (
    .clk             (clk_vga),
    .rst             (rst),
    .i_hit_en        (w_run_now & disp_i),
    .i_frame_restart (w_boundary),
    .i_hold_clear    (~w_run_next),
    .i_alpha         (alpha_i),
    .o_acc           (w_acc)
  );

  assign rgb_o         = r_rgb;
  assign crash_o       = r_crash;
  assign game_status_o = r_state;

endmodule

// File: tb/tb_frame_mixer.sv
// Self-checking bench for frame_mixer: mixing vector table, directed
// collision/FSM sequences and a randomized run against a frame-level model.
module tb_frame_mixer;
  import frame_mixer_pkg::*;

  localparam int N  = 4;
  localparam int W  = 12;
  localparam int NN = N * N;
  localparam logic [NN-1:0] MASK = 16'h0002;

  logic            clk_vga = 1'b0;
  logic            rst;
  logic            disp_i;
  logic            v_sync_i;
  logic [N*W-1:0]  rgb_i;
  logic [N-1:0]    alpha_i;
  logic            info_alpha_i;
  logic            gamestart_i;
  logic [W-1:0]    rgb_o;
  logic [NN-1:0]   crash_o;
  logic [1:0]      game_status_o;

  always #5 clk_vga = ~clk_vga;

  frame_mixer #(
    .N_LAYERS   (N),
    .RGB_W      (W),
    .BG_RGB     (12'h000),
    .INFO_RGB   (12'hFFF),
    .FATAL_MASK (MASK)
  ) dut (
    .clk_vga       (clk_vga),
    .rst           (rst),
    .disp_i        (disp_i),
    .v_sync_i      (v_sync_i),
    .rgb_i         (rgb_i),
    .alpha_i       (alpha_i),
    .info_alpha_i  (info_alpha_i),
    .gamestart_i   (gamestart_i),
    .rgb_o         (rgb_o),
    .crash_o       (crash_o),
    .game_status_o (game_status_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: status as an int, collisions as a set of layer pairs
  // seen during the current frame.
  logic [W-1:0]  m_rgb;
  logic [NN-1:0] m_crash;
  int            m_status;
  bit            m_pair [N][N];
  bit            m_vs_prev;

  function automatic logic [W-1:0] ref_mix(input logic disp, input logic info,
                                           input logic [N-1:0] alpha,
                                           input logic [N*W-1:0] rgb);
    if (!disp) return 12'h000;
    if (info)  return 12'hFFF;
    for (int k = 0; k < N; k++) if (alpha[k]) return rgb[k*W +: W];
    return 12'h000;
  endfunction

  function automatic logic [NN-1:0] pairs_as_vector();
    logic [NN-1:0] v = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (m_pair[i][j]) v[i*N+j] = 1'b1;
    return v;
  endfunction

  task automatic forget_pairs();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) m_pair[i][j] = 1'b0;
  endtask

  task automatic model_edge();
    int            nxt;
    bit            boundary;
    logic [NN-1:0] emitted;
    if (rst) begin
      m_rgb = '0; m_crash = '0; m_status = 0; m_vs_prev = 1'b1;
      forget_pairs();
      return;
    end
    boundary = m_vs_prev && !v_sync_i;
    emitted  = pairs_as_vector();
    nxt      = m_status;
    if (m_status == 0 && gamestart_i) nxt = 1;
    if (m_status == 1 && (m_crash & MASK) != 0) nxt = 2;
    if (m_status == 2 && gamestart_i) nxt = 1;
    m_crash = (m_status == 1 && boundary) ? emitted : '0;
    if (boundary) forget_pairs();
    if (m_status == 1 && disp_i)
      for (int i = 0; i < N; i++)
        for (int j = i + 1; j < N; j++)
          if (alpha_i[i] && alpha_i[j]) m_pair[i][j] = 1'b1;
    if (nxt != 1) forget_pairs();
    m_rgb     = ref_mix(disp_i, info_alpha_i, alpha_i, rgb_i);
    m_vs_prev = v_sync_i;
    m_status  = nxt;
  endtask

  task automatic step();
    @(posedge clk_vga);
    model_edge();
    #1;
    check("rgb_model",    rgb_o,         m_rgb);
    check("crash_model",  crash_o,       m_crash);
    check("status_model", game_status_o, m_status[1:0]);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  task automatic start_game();
    do_reset();
    gamestart_i = 1'b1; step(); gamestart_i = 1'b0;
  endtask

  typedef struct {
    logic           disp;
    logic           info;
    logic [N-1:0]   alpha;
    logic [N*W-1:0] rgb;
    logic [W-1:0]   exp;
  } mix_vec_t;

  mix_vec_t vecs [7];
  int       vcnt;

  initial begin
    rst = 1'b1; disp_i = 1'b1; v_sync_i = 1'b1; rgb_i = '0; alpha_i = '0;
    info_alpha_i = 1'b0; gamestart_i = 1'b0;

    do_reset();
    check("reset_rgb",    rgb_o,         12'h000);
    check("reset_crash",  crash_o,       16'h0000);
    check("reset_status", game_status_o, 2'd0);

    // rgb packed as {layer3, layer2, layer1, layer0}
    vecs[0] = '{1'b1, 1'b0, 4'b0110, {12'h000, 12'hF00, 12'h0F0, 12'h000}, 12'h0F0};
    vecs[1] = '{1'b1, 1'b1, 4'b0110, {12'h000, 12'hF00, 12'h0F0, 12'h000}, 12'hFFF};
    vecs[2] = '{1'b0, 1'b1, 4'b1111, {12'h111, 12'h222, 12'h333, 12'h444}, 12'h000};
    vecs[3] = '{1'b1, 1'b0, 4'b0000, {12'h111, 12'h222, 12'h333, 12'h444}, 12'h000};
    vecs[4] = '{1'b1, 1'b0, 4'b1000, {12'hABC, 12'h222, 12'h333, 12'h444}, 12'hABC};
    vecs[5] = '{1'b1, 1'b0, 4'b1111, {12'h111, 12'h222, 12'h333, 12'h123}, 12'h123};
    vecs[6] = '{1'b1, 1'b0, 4'b1010, {12'h789, 12'h222, 12'h456, 12'h444}, 12'h456};
    for (int v = 0; v < 7; v++) begin
      disp_i = vecs[v].disp; info_alpha_i = vecs[v].info;
      alpha_i = vecs[v].alpha; rgb_i = vecs[v].rgb;
      step();
      check($sformatf("mix_vec%0d", v), rgb_o, vecs[v].exp);
    end
    disp_i = 1'b1; info_alpha_i = 1'b0; alpha_i = '0; rgb_i = '0;

    // Non-fatal pair 2/3 over three pixels, one pulse, status stays RUN.
    start_game();
    check("start_status", game_status_o, 2'd1);
    alpha_i = 4'b1100; repeat (3) step();
    alpha_i = 4'b0000; step();
    v_sync_i = 1'b0; step();
    check("pulse_bit11", crash_o, 16'h0800);
    step();
    check("pulse_once", crash_o, 16'h0000);
    v_sync_i = 1'b1; step();
    check("nonfatal_run", game_status_o, 2'd1);

    // Fatal pair 0/1 ends the game; restart clears the matrix.
    start_game();
    alpha_i = 4'b0011; step();
    alpha_i = 4'b0000; step();
    v_sync_i = 1'b0; step();
    check("fatal_pulse", crash_o, 16'h0002);
    step();
    check("game_over", game_status_o, 2'd2);
    v_sync_i = 1'b1;
    gamestart_i = 1'b1; step(); gamestart_i = 1'b0;
    check("restart_run", game_status_o, 2'd1);
    step(); v_sync_i = 1'b0; step();
    check("restart_cleared", crash_o, 16'h0000);
    v_sync_i = 1'b1;

    // IDLE full frame with all layers overlapping.
    do_reset();
    alpha_i = 4'b1111; v_sync_i = 1'b0; step();
    v_sync_i = 1'b1; repeat (30) step();
    v_sync_i = 1'b0; step(); step();
    check("idle_no_crash", crash_o, 16'h0000);
    check("idle_status",   game_status_o, 2'd0);
    v_sync_i = 1'b1; alpha_i = '0;

    // Hit in the boundary cycle belongs to the next frame.
    start_game();
    step();
    alpha_i = 4'b0101; v_sync_i = 1'b0; step();
    check("boundary_hit_not_now", crash_o[2], 1'b0);
    alpha_i = 4'b0000; step();
    v_sync_i = 1'b1; repeat (3) step();
    v_sync_i = 1'b0; step();
    check("boundary_hit_next", crash_o, 16'h0004);
    v_sync_i = 1'b1; step();

    // Reset mid-frame with a populated matrix, and reset beating gamestart.
    start_game();
    alpha_i = 4'b1100; rgb_i = {4{12'h5A5}}; repeat (2) step();
    rst = 1'b1; gamestart_i = 1'b1; step();
    check("midrst_rgb",    rgb_o,         12'h000);
    check("midrst_crash",  crash_o,       16'h0000);
    check("midrst_status", game_status_o, 2'd0);
    rst = 1'b0; gamestart_i = 1'b0; alpha_i = '0;
    v_sync_i = 1'b0; step(); step();
    check("midrst_no_pulse", crash_o, 16'h0000);
    v_sync_i = 1'b1;

    // Randomized run against the model.
    vcnt = 0;
    for (int c = 0; c < 4000; c++) begin
      vcnt         = (vcnt + 1) % 60;
      v_sync_i     = (vcnt < 3) ? 1'b0 : 1'b1;
      disp_i       = ($urandom_range(7) != 0);
      info_alpha_i = ($urandom_range(15) == 0);
      for (int k = 0; k < N; k++) alpha_i[k] = ($urandom_range(5) == 0);
      rgb_i        = {$urandom, $urandom};
      gamestart_i  = ($urandom_range(39) == 0);
      rst          = ($urandom_range(599) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
